// File: rtl/led_pkg.sv
// Shared constants for the LED pattern sequencer: step-mode codes and default reset pattern.
package led_pkg;

  localparam logic [1:0] MODE_ROTL   = 2'd0;
  localparam logic [1:0] MODE_ROTR   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam logic [11:0] BASE_PATTERN_DEFAULT = 12'b000011101101;

endpackage

// File: rtl/led_tick_div.sv
// Step-rate divider: counts 0..TICK_CNT-1, freezes while paused, pulses tick on the last count.
module led_tick_div #(
  parameter int unsigned TICK_CNT = 16777217
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_CNT - 1)) && !pause;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (!pause) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: rotates/bounces/holds a pattern once per divider tick.
// Optional macro LED_PWM_EN adds a 4-bit brightness input gating the LED drive.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int unsigned      LED_W        = 12,
  parameter int unsigned      TICK_CNT     = 16777217,
  parameter logic [LED_W-1:0] BASE_PATTERN = LED_W'(BASE_PATTERN_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [LED_W-1:0] pattern,
  input  logic             load,
  input  logic             pause,
`ifdef LED_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic [LED_W-1:0] led,
  output logic             step_tick,
  output logic             wrap
);

  // Wide enough to hold the bounce period 2*(LED_W-1).
  localparam int unsigned SW = $clog2(2 * LED_W);

  logic             tick;
  logic [LED_W-1:0] led_q, led_d, led_rotl, led_rotr;
  logic [SW-1:0]    step_q, step_d, step_inc;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q;
  logic             step_tick_q, step_tick_d;
  logic             wrap_q, wrap_d;

  led_tick_div #(
    .TICK_CNT (TICK_CNT)
  ) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .pause (pause),
    .clear (load),
    .tick  (tick)
  );

  assign led_rotl = {led_q[LED_W-2:0], led_q[LED_W-1]};
  assign led_rotr = {led_q[0], led_q[LED_W-1:1]};
  assign step_inc = step_q + 1'b1;

  always_comb begin
    led_d       = led_q;
    step_d      = step_q;
    dir_d       = dir_q;
    step_tick_d = 1'b0;
    wrap_d      = 1'b0;

    if (load) begin
      led_d  = pattern;
      step_d = '0;
      dir_d  = 1'b0;
    end else begin
      if (tick) begin
        step_tick_d = 1'b1;
        unique case (mode_q)
          MODE_ROTL:   led_d = led_rotl;
          MODE_ROTR:   led_d = led_rotr;
          MODE_BOUNCE: led_d = dir_q ? led_rotr : led_rotl;
          MODE_HOLD:   led_d = led_q;
        endcase

        if (mode_q == MODE_BOUNCE) begin
          if (step_inc == SW'(2 * (LED_W - 1))) begin
            step_d = '0;
            dir_d  = 1'b0;
            wrap_d = 1'b1;
          end else begin
            step_d = step_inc;
            // Turn around once the lit end has been reached.
            if (step_inc == SW'(LED_W - 1)) begin
              dir_d = ~dir_q;
            end
          end
        end else if (step_q == SW'(LED_W - 1)) begin
          step_d = '0;
          wrap_d = 1'b1;
        end else begin
          step_d = step_inc;
        end
      end

      // A mode change restarts the sequence; led keeps its current value.
      if (mode != mode_q) begin
        step_d = '0;
        dir_d  = 1'b0;
        wrap_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q       <= BASE_PATTERN;
      step_q      <= '0;
      dir_q       <= 1'b0;
      mode_q      <= MODE_ROTL;
      step_tick_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      led_q       <= led_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      mode_q      <= mode;
      step_tick_q <= step_tick_d;
      wrap_q      <= wrap_d;
    end
  end

  assign step_tick = step_tick_q;
  assign wrap      = wrap_q;

`ifdef LED_PWM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign led = led_q & {LED_W{pwm_q < bright}};
`else
  assign led = led_q;
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq (LED_W=8, TICK_CNT=4, BASE_PATTERN=8'h01).
module tb_led_pattern_seq;
  import led_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned TC = 4;
  localparam logic [7:0]  BASE = 8'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] pattern = 8'h00;
  logic       load = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] led;
  logic       step_tick, wrap;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: current pattern, divider phase, steps into the sequence, registered mode.
  logic [7:0] m_led;
  int         m_div, m_steps, m_mode;
  bit         m_st, m_wr;

  led_pattern_seq #(
    .LED_W        (W),
    .TICK_CNT     (TC),
    .BASE_PATTERN (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .pattern   (pattern),
    .load      (load),
    .pause     (pause),
    .led       (led),
    .step_tick (step_tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] x);
    return (x << 1) | (x >> (W - 1));
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] x);
    return (x >> 1) | (x << (W - 1));
  endfunction

  task automatic model_edge(input logic r, input logic [1:0] md, input logic [7:0] pat,
                            input logic ld, input logic ps);
    bit tk, left;
    int period;
    if (!r) begin
      m_led = BASE; m_div = 0; m_steps = 0; m_mode = 0; m_st = 0; m_wr = 0;
      return;
    end
    tk = (m_div == TC - 1) && !ps;
    m_st = 0;
    m_wr = 0;
    if (ld) begin
      m_led = pat; m_div = 0; m_steps = 0;
    end else begin
      if (tk) begin
        m_div  = 0;
        m_st   = 1;
        period = (m_mode == 2) ? 2 * (W - 1) : W;
        left   = (m_mode == 0) || (m_mode == 2 && m_steps < W - 1);
        if (m_mode != 3) m_led = left ? rotl(m_led) : rotr(m_led);
        m_steps++;
        if (m_steps == period) begin
          m_steps = 0;
          m_wr    = 1;
        end
      end else if (!ps) begin
        m_div++;
      end
      if (int'(md) != m_mode) begin
        m_steps = 0;
        m_wr    = 0;
      end
    end
    m_mode = int'(md);
  endtask

  task automatic drive(input logic r, input logic [1:0] md, input logic [7:0] pat,
                       input logic ld, input logic ps);
    rst = r; mode = md; pattern = pat; load = ld; pause = ps;
    model_edge(r, md, pat, ld, ps);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'd3, 8'hFF, 1'b1, 1'b0);
      n_cmp++;
      if ({led, step_tick, wrap} !== {BASE, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset: led=%h st=%b wr=%b, expected led=%h st=0 wr=0",
                 led, step_tick, wrap, BASE);
      end
    end
  endtask

  task automatic test_rotl();
    int steps = 0, wraps = 0, wrap_cyc = 0;
    for (int i = 1; i <= 32; i++) begin
      drive(1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if ({led, step_tick, wrap} !== {m_led, m_st, m_wr}) begin
        n_fail++;
        $display("FAIL rotl cyc %0d: led=%h st=%b wr=%b, expected led=%h st=%b wr=%b",
                 i, led, step_tick, wrap, m_led, m_st, m_wr);
      end
      steps += int'(step_tick);
      if (wrap) begin wraps++; wrap_cyc = i; end
    end
    n_cmp++;
    if (steps != 8 || wraps != 1 || wrap_cyc != 32 || led !== 8'h01) begin
      n_fail++;
      $display("FAIL rotl_seq: steps=%0d wraps=%0d wrap_cyc=%0d led=%h, expected 8 1 32 01",
               steps, wraps, wrap_cyc, led);
    end
  endtask

  task automatic test_rotr();
    int steps = 0, wraps = 0, wrap_cyc = 0;
    logic [7:0] first = 8'h00;
    drive(1'b1, MODE_ROTR, 8'h81, 1'b1, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      drive(1'b1, MODE_ROTR, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if ({led, step_tick, wrap} !== {m_led, m_st, m_wr}) begin
        n_fail++;
        $display("FAIL rotr cyc %0d: led=%h st=%b wr=%b, expected led=%h st=%b wr=%b",
                 i, led, step_tick, wrap, m_led, m_st, m_wr);
      end
      if (step_tick && steps == 0) first = led;
      steps += int'(step_tick);
      if (wrap) begin wraps++; wrap_cyc = i; end
    end
    n_cmp++;
    if (first !== 8'hC0 || wraps != 1 || wrap_cyc != 32 || led !== 8'h81) begin
      n_fail++;
      $display("FAIL rotr_seq: first=%h wraps=%0d wrap_cyc=%0d led=%h, expected C0 1 32 81",
               first, wraps, wrap_cyc, led);
    end
  endtask

  task automatic test_bounce();
    int steps = 0, wraps = 0, wrap_cyc = 0;
    logic [7:0] at7 = 8'h00;
    drive(1'b1, MODE_BOUNCE, 8'h01, 1'b1, 1'b0);
    for (int i = 1; i <= 56; i++) begin
      drive(1'b1, MODE_BOUNCE, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if ({led, step_tick, wrap} !== {m_led, m_st, m_wr}) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: led=%h st=%b wr=%b, expected led=%h st=%b wr=%b",
                 i, led, step_tick, wrap, m_led, m_st, m_wr);
      end
      steps += int'(step_tick);
      if (step_tick && steps == 7) at7 = led;
      if (wrap) begin wraps++; wrap_cyc = i; end
    end
    n_cmp++;
    if (at7 !== 8'h80 || wraps != 1 || wrap_cyc != 56 || led !== 8'h01) begin
      n_fail++;
      $display("FAIL bounce_seq: step7=%h wraps=%0d wrap_cyc=%0d led=%h, expected 80 1 56 01",
               at7, wraps, wrap_cyc, led);
    end
    // Second sequence must start leftwards again.
    for (int i = 0; i < 4; i++) drive(1'b1, MODE_BOUNCE, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (led !== 8'h02 || !step_tick) begin
      n_fail++;
      $display("FAIL bounce_restart: led=%h st=%b, expected led=02 st=1", led, step_tick);
    end
  endtask

  task automatic test_load_tick();
    int lat = 0;
    drive(1'b1, MODE_ROTL, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b0);
    drive(1'b1, MODE_ROTL, 8'hA5, 1'b1, 1'b0);
    n_cmp++;
    if (led !== 8'hA5 || step_tick !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL load_tick: led=%h st=%b wr=%b, expected led=a5 st=0 wr=0",
               led, step_tick, wrap);
    end
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      drive(1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b0);
      if (step_tick) lat = i;
    end
    n_cmp++;
    if (lat != 4 || led !== 8'h4B) begin
      n_fail++;
      $display("FAIL load_latency: cycles=%0d led=%h, expected 4 4b", lat, led);
    end
  endtask

  task automatic test_pause();
    int bad = 0, lat = 0;
    drive(1'b1, MODE_ROTL, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b1);
      if (step_tick || led !== 8'h01) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pause_hold: %0d bad cycles, expected 0", bad);
    end
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      drive(1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b0);
      if (step_tick) lat = i;
    end
    n_cmp++;
    if (lat != 2 || led !== 8'h02) begin
      n_fail++;
      $display("FAIL pause_resume: cycles=%0d led=%h, expected 2 02", lat, led);
    end
  endtask

  task automatic test_const_pattern();
    int steps = 0, wraps = 0, bad = 0;
    drive(1'b1, MODE_ROTL, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b0);
      if (led !== 8'hFF) bad++;
      steps += int'(step_tick);
      wraps += int'(wrap);
    end
    n_cmp++;
    if (bad != 0 || steps != 8 || wraps != 1) begin
      n_fail++;
      $display("FAIL all_ones: bad=%0d steps=%0d wraps=%0d, expected 0 8 1", bad, steps, wraps);
    end
  endtask

  task automatic test_reset_mid_bounce();
    drive(1'b1, MODE_BOUNCE, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) drive(1'b1, MODE_BOUNCE, 8'h00, 1'b0, 1'b0);
    drive(1'b0, MODE_BOUNCE, 8'h3C, 1'b1, 1'b0);
    n_cmp++;
    if ({led, step_tick, wrap} !== {8'h01, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_bounce: led=%h st=%b wr=%b, expected led=01 st=0 wr=0",
               led, step_tick, wrap);
    end
  endtask

  task automatic test_random();
    logic [1:0] md = MODE_ROTL;
    logic [7:0] pat;
    logic r, ld, ps;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) md = 2'($urandom_range(0, 3));
      r   = ($urandom_range(0, 199) != 0);
      ld  = ($urandom_range(0, 39) == 0);
      ps  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       pat = 8'h00;
        1:       pat = 8'hFF;
        default: pat = 8'($urandom);
      endcase
      drive(r, md, pat, ld, ps);
      n_cmp++;
      if ({led, step_tick, wrap} !== {m_led, m_st, m_wr}) begin
        n_fail++;
        $display("FAIL random cyc %0d: led=%h st=%b wr=%b, expected led=%h st=%b wr=%b",
                 i, led, step_tick, wrap, m_led, m_st, m_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotl();
    test_rotr();
    test_bounce();
    test_load_tick();
    test_pause();
    test_const_pattern();
    test_reset_mid_bounce();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 SHALL have parameter LED_W, default 12: number of LED outputs, legal range 4..32.
REQ-002 SHALL have parameter TICK_CNT, default 16777217: clk cycles per pattern step, minimum 2.
REQ-003 SHALL have parameter BASE_PATTERN, default 12'b000011101101 (zero-extended/truncated to LED_W): the pattern loaded at reset.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port mode, input, 2: step mode; 0 ROTL, 1 ROTR, 2 BOUNCE, 3 HOLD.
REQ-007 SHALL have port pattern, input, LED_W: value captured on load.
REQ-008 SHALL have port load, input, 1: single-cycle strobe that captures pattern.
REQ-009 SHALL have port pause, input, 1: freezes the tick divider while high.
REQ-010 SHALL have port led, output, LED_W: registered LED drive.
REQ-011 SHALL have port step_tick, output, 1: one-cycle pulse on each pattern step.
REQ-012 SHALL have port wrap, output, 1: one-cycle pulse coincident with the step that completes a full sequence.

Function
REQ-013 SHALL count the divider 0..TICK_CNT-1, raise tick when count==TICK_CNT-1 and pause==0, and then return to 0; count SHALL hold while pause==1.
REQ-014 SHALL on tick in ROTL set led <= {led[LED_W-2:0],led[LED_W-1]}; in ROTR set led <= {led[0],led[LED_W-1:1]}; in HOLD keep led unchanged while still pulsing step_tick.
REQ-015 SHALL keep a step counter: ROTL/ROTR/HOLD wrap it from LED_W-1 to 0, and wrap SHALL pulse on that step.
REQ-016 SHALL in BOUNCE rotate by dir (0 = left, 1 = right), toggle dir on the step that brings the counter to LED_W-1, return the counter to 0 and pulse wrap after 2*(LED_W-1) steps, and start each sequence with dir = 0.
REQ-017 SHALL on load==1 set led <= pattern, clear divider, step counter and dir, and suppress step_tick/wrap that cycle; load SHALL win over a simultaneous tick.
REQ-018 SHALL register mode each cycle, and on any change clear the step counter and dir without altering led; the new mode SHALL apply from the next tick.
REQ-019 SHALL produce step_tick and wrap as registered pulses, each high for exactly one cycle, in the same cycle in which led shows the new value.
REQ-020 SHALL tolerate an all-zero or all-one pattern (rotation keeps it constant; tick and wrap pulses continue).

Reset
REQ-021 SHALL on rst==0 at a clk edge set led=BASE_PATTERN, divider=0, step=0, dir=0, step_tick=0, wrap=0, mode register=0.
REQ-022 SHALL give reset priority over load and tick, and SHALL abandon any in-progress sequence when reset is applied.

Configuration
REQ-023 SHALL, with macro LED_PWM_EN defined, add input bright[3:0] and a free-running 4-bit PWM counter (reset 0), and drive led = led_reg AND replicated (pwm_cnt < bright); bright=0 gives a dark output.
REQ-024 SHALL, without LED_PWM_EN, omit the bright port and the PWM counter, and drive led = led_reg directly.

Structure
REQ-025 SHALL place mode constants (MODE_ROTL=0, MODE_ROTR=1, MODE_BOUNCE=2, MODE_HOLD=3) and the default BASE_PATTERN in shared package led_pkg.
REQ-026 SHALL implement the divider (count, pause, clear, tick) as sub-module led_tick_div, parameterised by TICK_CNT.

Verification (LED_W=8, TICK_CNT=4, BASE_PATTERN=8'h01)
REQ-027 SHALL cover: reset then ROTL for 32 cycles -> led 01,02,04,...,80,01 with a step every 4 cycles and wrap coincident with 80->01.
REQ-028 SHALL cover: ROTR from 8'h81 -> C0,60,30,...; wrap after 8 steps.
REQ-029 SHALL cover: BOUNCE from 01 -> 02..80 over 7 steps, then 40..01 over 7 steps; wrap on step 14; dir back to left.
REQ-030 SHALL cover: load=1 with pattern=8'hA5 on the same cycle as a tick -> led=A5, no step_tick, next step 4 cycles later.
REQ-031 SHALL cover: pause high for 10 cycles mid-count -> no steps and led stable; on release, stepping resumes from the frozen count.
REQ-032 SHALL cover: rst low mid-BOUNCE -> next cycle led=01, step_tick=0, wrap=0; with LED_PWM_EN, bright=4 gives led=led_reg for 4 of every 16 cycles.
